// File: rtl/trdb_trace_ctrl_if.sv
// Control/handshake bundle between the trigger/filter/emitter side and the trace session sequencer.
// The master side drives requests and acks; the slave (sequencer) drives enables, packet requests and counters.
interface trdb_trace_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             trace_activated_i;
    logic             trace_req_on_i;
    logic             trace_req_off_i;
    logic             emitter_busy_i;
    logic             pkt_ack_i;
    logic             trace_enable_o;
    logic             start_pkt_req_o;
    logic             stop_pkt_req_o;
    logic             busy_o;
    logic [CNT_W-1:0] session_cnt_o;
    logic [CNT_W-1:0] timeout_cnt_o;

    modport master (
        output trace_activated_i, trace_req_on_i, trace_req_off_i, emitter_busy_i, pkt_ack_i,
        input  trace_enable_o, start_pkt_req_o, stop_pkt_req_o, busy_o, session_cnt_o, timeout_cnt_o
    );

    modport slave (
        input  trace_activated_i, trace_req_on_i, trace_req_off_i, emitter_busy_i, pkt_ack_i,
        output trace_enable_o, start_pkt_req_o, stop_pkt_req_o, busy_o, session_cnt_o, timeout_cnt_o
    );
endinterface

// File: rtl/trdb_trace_ctrl.sv
// Trace session sequencer: start packet -> tracing -> bounded emitter drain -> stop packet.
// Outputs are decoded from the state register, so a request shows up one cycle after it is sampled.
module trdb_trace_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    trdb_trace_ctrl_if.slave bus
);
    localparam int unsigned      DW         = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TRACING,
        S_DRAIN,
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] session_q, session_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;

    logic go, stop;
    logic trace_enable, start_req, stop_req, busy;

    assign go   = bus.trace_activated_i & bus.trace_req_on_i & ~bus.trace_req_off_i;
    assign stop = ~bus.trace_activated_i | bus.trace_req_off_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            session_q <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            session_q <= session_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        session_d    = session_q;
        timeout_d    = timeout_q;
        trace_enable = 1'b0;
        start_req    = 1'b0;
        stop_req     = 1'b0;
        busy         = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_START;
            end
            S_START: begin
                start_req = 1'b1;
                // An ack that coincides with stop means the start packet went out,
                // so the session proceeds and is closed by a matching stop packet.
                if (bus.pkt_ack_i)  state_d = S_TRACING;
                else if (stop)      state_d = S_IDLE;
            end
            S_TRACING: begin
                trace_enable = 1'b1;
                if (stop) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (!bus.emitter_busy_i) begin
                    state_d = S_STOP;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_STOP;
                    if (timeout_q != CNT_MAX) timeout_d = timeout_q + 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_STOP: begin
                stop_req = 1'b1;
                if (bus.pkt_ack_i) begin
                    state_d = S_IDLE;
                    if (session_q != CNT_MAX) session_d = session_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.trace_enable_o  = trace_enable;
    assign bus.start_pkt_req_o = start_req;
    assign bus.stop_pkt_req_o  = stop_req;
    assign bus.busy_o          = busy;
    assign bus.session_cnt_o   = session_q;
    assign bus.timeout_cnt_o   = timeout_q;
endmodule
